tf_zram_ctrl: RTL and testbench
===============================

Name: tf_zram_ctrl

Overview:
Parametrised Zorro II autoconfig and zero-wait/N-wait fast-RAM controller for the 68030 accelerator local bus.
- Presents one autoconfig board at $E80000, accepts its base address, then decodes a 2^SIZE_LOG2-byte SRAM window.
- Generates STERM-terminated synchronous cycles with programmable wait states.
- Supports optional 4-beat cache-line bursts (CBREQ/CBACK) with an internal wrapping longword counter.

Parameters:
SIZE_LOG2, 22, RAM window size log2 in bytes; legal values 19..22 (512K..4M).
WAIT_STATES, 0, CLKCPU cycles inserted before each STERM; legal values 0..7.
MANUF_ID, 16'h07DB, autoconfig manufacturer number.
PRODUCT_ID, 8'h01, autoconfig product number.

Ports:
CLKCPU  in  1  CPU clock; all state changes on its rising edge.
RESET  in  1  synchronous, active-low reset, sampled on CLKCPU.
A  in  23  CPU address A[23:1].
A0  in  1  CPU address bit 0.
SIZ  in  2  68030 transfer size.
D  inout  8  data D[31:24] (nibble D[7:4] used for autoconfig).
AS20  in  1  address strobe, active low.
DS20  in  1  data strobe, active low.
RW20  in  1  1 = read.
CBREQ  in  1  burst request, active low.
CBACK  out  1  burst acknowledge, active low.
CIIN  out  1  cache inhibit, active low.
STERM  out  1  synchronous termination, active low.
INTCYCLE  out  1  low = cycle claimed locally (drives OVR).
RAMCS  out  4  byte-lane chip selects, active low; [3] = D[31:24].
RAMOE  out  1  SRAM output enable, active low.
RAMWE  out  1  SRAM write enable, active low.
RAMA  out  2  SRAM longword address A[3:2], burst-counted.
CONFIGURED  out  1  high once the base address has been written.

Behaviour:
- Reset values: STERM=1, CBACK=1, CIIN=1, INTCYCLE=1, RAMCS=4'hF, RAMOE=1, RAMWE=1, D=Z, CONFIGURED=0, shutup=0, base=8'h00, FSM=IDLE.
- Z2 decode: A[23:16]==8'hE8, AS20=0, DS20=0, CONFIGURED=0, shutup=0. zaddr = {A[7:2],A1}.
- Z2 reads: D[7:4] driven one cycle after decode; D[3:0]=4'hF. D is Z whenever decode is false.
  - zaddr 00: type nibble 4'hE.
  - zaddr 01: {1'b0, size code}, where size code = 7 − (22 − SIZE_LOG2).
  - zaddr 02/03: ~PRODUCT_ID nibbles, high nibble first.
  - zaddr 08..0B: ~MANUF_ID nibbles, high nibble first.
  - All other offsets: 4'hF.
- Z2 writes (registered, RW20=0):
  - zaddr 25: base[3:0] <= D[7:4].
  - zaddr 24: base[7:4] <= D[7:4]; CONFIGURED <= 1.
  - zaddr 26: shutup <= 1.
- RAM hit: CONFIGURED=1, AS20=0, A[23:SIZE_LOG2]==base[7:SIZE_LOG2-16].
  - INTCYCLE is combinational and low on a hit.
  - CIIN stays high (RAM is cacheable).
- FSM states: IDLE, WAIT, TERM, BWAIT, BTERM, HOLD.
  - IDLE: on hit, load the wait counter with WAIT_STATES and RAMA<=A[3:2]. Go to WAIT if WAIT_STATES>0, else TERM.
  - WAIT: decrement the counter; go to TERM at 1.
  - TERM: STERM=0 for exactly one cycle.
    - If the burst feature is present, CBREQ=0 and the cycle is a read: CBACK=0, beat count=1, go to BWAIT/BTERM.
    - Otherwise go to HOLD.
  - BTERM: RAMA<=RAMA+1 (mod 4, wrap 3->0), STERM=0, beat count increments.
    - After the 4th beat, CBACK=1 and go to HOLD.
    - CBACK deasserts on the 4th beat.
  - HOLD: outputs idle; return to IDLE when AS20=1.
- AS20 negated in any non-IDLE state: abort to IDLE next edge; STERM and CBACK go high immediately.
- RAMCS: byte-lane decode from SIZ/A1/A0 per 68030 dynamic bus sizing; forced 4'h0 on burst beats; 4'hF when there is no hit.
- Strobes: RAMOE = ~(hit & RW20). RAMWE = ~(hit & ~RW20 & ~DS20).
- Reset mid-cycle: all outputs go to reset values on the next edge, regardless of state.
- RAM and Z2 decodes never overlap once configured: Z2 is disabled after CONFIGURED=1.

Optional Feature:
TF_ZRAM_BURST_EN.
- Defined: burst path as above.
- Undefined: CBACK is tied to 1, BWAIT/BTERM are not built, and every hit is single-beat.

Test Plan:
- Reset, then read zaddr 00/01/08 with defaults -> D[7:4]=E, 7, ~0=F (MANUF_ID high nibble 0); D is Z otherwise.
- Write 4'h2 at zaddr 25, then 4'h4 at zaddr 24 -> CONFIGURED=1, base=8'h42; access at $400000 -> INTCYCLE=0; access at $E80000 -> no D drive.
- WAIT_STATES=2, longword read hit -> STERM low exactly on the 3rd edge after AS20 falls, RAMCS=4'h0, RAMOE=0.
- Burst enabled, read at A[3:2]=2 with CBREQ=0 -> CBACK=0, 4 STERM pulses, RAMA sequence 2,3,0,1; CBACK=1 on the 4th beat.
- Byte write at A0=1, A1=0 -> RAMCS=4'b1011, RAMWE low while DS20=0.
- AS20 raised during WAIT -> IDLE next edge, no STERM pulse; RESET=0 during BTERM -> all outputs at reset values.

Source files
------------

// File: rtl/tf_zram_ctrl.sv
// Zorro II autoconfig board plus STERM-terminated fast-RAM controller for the 68030 local bus.
// Define TF_ZRAM_BURST_EN to build the 4-beat CBREQ/CBACK cache-line burst path.
module tf_zram_ctrl #(
  parameter int          SIZE_LOG2   = 22,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] MANUF_ID    = 16'h07DB,
  parameter logic [7:0]  PRODUCT_ID  = 8'h01
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic        A0,
  input  logic [1:0]  SIZ,
  inout  wire  [7:0]  D,
  input  logic        AS20,
  input  logic        DS20,
  input  logic        RW20,
  input  logic        CBREQ,
  output logic        CBACK,
  output logic        CIIN,
  output logic        STERM,
  output logic        INTCYCLE,
  output logic [3:0]  RAMCS,
  output logic        RAMOE,
  output logic        RAMWE,
  output logic [1:0]  RAMA,
  output logic        CONFIGURED
);

  localparam logic [2:0] SIZE_CODE = 3'(7 - (22 - SIZE_LOG2));
  localparam logic [2:0] WS        = 3'(WAIT_STATES);

`ifdef TF_ZRAM_BURST_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TERM, S_BWAIT, S_BTERM, S_HOLD} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TERM, S_HOLD} state_t;
`endif

  state_t      state;
  logic        shutup;
  logic [7:0]  base;
  logic [6:0]  zaddr;
  logic        z2_dec;
  logic        hit;
  logic [3:0]  z2_nib;
  logic [3:0]  z2_dat_q;
  logic        z2_oe_q;
  logic        sterm_q;
  logic        cback_q;
  logic [2:0]  cnt;
  logic [1:0]  beat;
  logic        burst_req;
  logic        in_burst;
  logic [2:0]  len;
  logic [3:0]  lanes;
  logic        unused_bits;

  assign zaddr  = A[7:1];
  assign z2_dec = (A[23:16] == 8'hE8) & ~AS20 & ~DS20 & ~CONFIGURED & ~shutup;
  assign hit    = CONFIGURED & ~AS20 & (A[23:SIZE_LOG2] == base[7:SIZE_LOG2-16]);

  always_comb begin
    z2_nib = 4'hF;
    case (zaddr)
      7'h00:   z2_nib = 4'hE;
      7'h01:   z2_nib = {1'b0, SIZE_CODE};
      7'h02:   z2_nib = ~PRODUCT_ID[7:4];
      7'h03:   z2_nib = ~PRODUCT_ID[3:0];
      7'h08:   z2_nib = ~MANUF_ID[15:12];
      7'h09:   z2_nib = ~MANUF_ID[11:8];
      7'h0A:   z2_nib = ~MANUF_ID[7:4];
      7'h0B:   z2_nib = ~MANUF_ID[3:0];
      default: z2_nib = 4'hF;
    endcase
  end

  // Lanes [3:0] map to byte offsets 0..3; enable offsets from A1:A0 up to A1:A0+len-1.
  always_comb begin
    len   = (SIZ == 2'b00) ? 3'd4 : {1'b0, SIZ};
    lanes = (4'hF >> {A[1], A0}) & ~(4'hF >> ({1'b0, A[1], A0} + len));
  end

  assign D        = (z2_oe_q & z2_dec & RW20) ? {z2_dat_q, 4'hF} : 8'hzz;
  assign INTCYCLE = ~hit;
  assign CIIN     = 1'b1;
  assign RAMOE    = ~(hit & RW20);
  assign RAMWE    = ~(hit & ~RW20 & ~DS20);
  assign RAMCS    = ~hit ? 4'hF : (in_burst ? 4'h0 : ~lanes);
  assign STERM    = sterm_q | AS20;

`ifdef TF_ZRAM_BURST_EN
  assign burst_req   = ~CBREQ & RW20;
  assign in_burst    = (state == S_BWAIT) | (state == S_BTERM);
  assign CBACK       = cback_q | AS20;
  assign unused_bits = ^{A[15:8], D[3:0], base};
`else
  assign burst_req   = 1'b0;
  assign in_burst    = 1'b0;
  assign CBACK       = 1'b1;
  assign unused_bits = ^{A[15:8], D[3:0], base, CBREQ, cback_q, beat};
`endif

  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state      <= S_IDLE;
      sterm_q    <= 1'b1;
      cback_q    <= 1'b1;
      cnt        <= 3'd0;
      beat       <= 2'd0;
      RAMA       <= 2'd0;
      CONFIGURED <= 1'b0;
      shutup     <= 1'b0;
      base       <= 8'h00;
      z2_oe_q    <= 1'b0;
      z2_dat_q   <= 4'hF;
    end else begin
      z2_oe_q  <= z2_dec & RW20;
      z2_dat_q <= z2_nib;
      if (z2_dec & ~RW20) begin
        case (zaddr)
          7'h24: begin base[7:4] <= D[7:4]; CONFIGURED <= 1'b1; end
          7'h25: base[3:0] <= D[7:4];
          7'h26: shutup <= 1'b1;
          default: ;
        endcase
      end

      // Address strobe negation ends any cycle, including the normal exit from HOLD.
      if (AS20 && state != S_IDLE) begin
        state   <= S_IDLE;
        sterm_q <= 1'b1;
        cback_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (hit) begin
            RAMA <= A[3:2];
            cnt  <= WS;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
            end else begin
              state   <= S_TERM;
              sterm_q <= 1'b0;
              cback_q <= ~burst_req;
              beat    <= 2'd1;
            end
          end
          S_WAIT: if (cnt == 3'd1) begin
            state   <= S_TERM;
            sterm_q <= 1'b0;
            cback_q <= ~burst_req;
            beat    <= 2'd1;
          end else begin
            cnt <= cnt - 3'd1;
          end
`ifdef TF_ZRAM_BURST_EN
          // cback_q high during a beat means single-beat cycle or the last burst beat.
          S_TERM, S_BTERM: if (cback_q) begin
            state   <= S_HOLD;
            sterm_q <= 1'b1;
          end else if (WAIT_STATES > 0) begin
            state   <= S_BWAIT;
            cnt     <= WS;
            sterm_q <= 1'b1;
          end else begin
            state   <= S_BTERM;
            RAMA    <= RAMA + 2'd1;
            beat    <= beat + 2'd1;
            cback_q <= (beat == 2'd3);
          end
          S_BWAIT: if (cnt == 3'd1) begin
            state   <= S_BTERM;
            sterm_q <= 1'b0;
            RAMA    <= RAMA + 2'd1;
            beat    <= beat + 2'd1;
            cback_q <= (beat == 2'd3);
          end else begin
            cnt <= cnt - 3'd1;
          end
`else
          S_TERM: begin
            state   <= S_HOLD;
            sterm_q <= 1'b1;
          end
`endif
          S_HOLD: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tf_zram_ctrl.sv
// Bench for tf_zram_ctrl: directed autoconfig/reset/abort steps plus randomized RAM cycles
// checked against a byte-range and beat-schedule reference model.
module tb_tf_zram_ctrl;
  localparam int          SIZE_LOG2 = 22;
  localparam int          WS        = 2;
  localparam logic [15:0] MANUF     = 16'h07DB;
  localparam logic [7:0]  PROD      = 8'h01;
`ifdef TF_ZRAM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        CLKCPU = 1'b0;
  logic        RESET;
  logic [23:1] A;
  logic        A0;
  logic [1:0]  SIZ;
  tri0  [7:0]  D;          // undriven bus reads as 8'h00
  logic        AS20, DS20, RW20, CBREQ;
  logic        CBACK, CIIN, STERM, INTCYCLE;
  logic [3:0]  RAMCS;
  logic        RAMOE, RAMWE;
  logic [1:0]  RAMA;
  logic        CONFIGURED;
  logic        tb_d_oe;
  logic [7:0]  tb_d_val;

  assign D = tb_d_oe ? tb_d_val : 8'hzz;
  always #5 CLKCPU = ~CLKCPU;

  int n_chk  = 0;
  int n_pass = 0;
  bit cfg_model  = 1'b0;
  int base_model = 0;

  tf_zram_ctrl #(.SIZE_LOG2(SIZE_LOG2), .WAIT_STATES(WS), .MANUF_ID(MANUF), .PRODUCT_ID(PROD)) dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .A(A), .A0(A0), .SIZ(SIZ), .D(D),
    .AS20(AS20), .DS20(DS20), .RW20(RW20), .CBREQ(CBREQ),
    .CBACK(CBACK), .CIIN(CIIN), .STERM(STERM), .INTCYCLE(INTCYCLE),
    .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE), .RAMA(RAMA), .CONFIGURED(CONFIGURED)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] z2_expect(input int za);
    logic [15:0] m;
    logic [7:0]  p;
    m = ~MANUF;
    p = ~PROD;
    if (za == 0) return 4'hE;
    if (za == 1) return 4'(7 - (22 - SIZE_LOG2));
    if (za == 2) return p[7:4];
    if (za == 3) return p[3:0];
    if (za >= 8 && za <= 11) return 4'(m >> (4 * (11 - za)));
    return 4'hF;
  endfunction

  // Active-low chip selects: clear the bit of every byte offset the transfer covers.
  function automatic logic [3:0] lane_cs(input int off, input logic [1:0] siz);
    int n;
    logic [3:0] cs;
    n  = (siz == 2'b00) ? 4 : int'(siz);
    cs = 4'hF;
    for (int b = off; b < 4 && b < off + n; b++) cs[3 - b] = 1'b0;
    return cs;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_sterm"}, STERM, 1);
    chk({pfx, "_cback"}, CBACK, 1);
    chk({pfx, "_ciin"}, CIIN, 1);
    chk({pfx, "_intcycle"}, INTCYCLE, 1);
    chk({pfx, "_ramcs"}, RAMCS, 4'hF);
    chk({pfx, "_ramoe"}, RAMOE, 1);
    chk({pfx, "_ramwe"}, RAMWE, 1);
    chk({pfx, "_configured"}, CONFIGURED, 0);
    chk({pfx, "_d"}, D, 8'h00);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    repeat (2) @(negedge CLKCPU);
    check_reset_outputs("reset");
    RESET = 1'b1;
    cfg_model  = 1'b0;
    base_model = 0;
  endtask

  task automatic drive_addr(input logic [23:0] addr);
    A  = addr[23:1];
    A0 = addr[0];
  endtask

  task automatic z2_read(input int za, input logic [3:0] nib, input bit drives);
    @(negedge CLKCPU);
    drive_addr(24'hE80000 | 24'(za << 1));
    RW20 = 1'b1; AS20 = 1'b0; DS20 = 1'b0;
    #1;
    chk("z2_first_cycle_d", D, 8'h00);
    @(negedge CLKCPU);
    chk("z2_read_d", D, drives ? {nib, 4'hF} : 8'h00);
    chk("z2_intcycle", INTCYCLE, 1);
    AS20 = 1'b1; DS20 = 1'b1;
    #1;
    chk("z2_release_d", D, 8'h00);
  endtask

  task automatic z2_write(input int za, input logic [3:0] nib);
    @(negedge CLKCPU);
    drive_addr(24'hE80000 | 24'(za << 1));
    RW20 = 1'b0; AS20 = 1'b0; DS20 = 1'b0;
    tb_d_val = {nib, 4'h0}; tb_d_oe = 1'b1;
    @(negedge CLKCPU);
    AS20 = 1'b1; DS20 = 1'b1; RW20 = 1'b1; tb_d_oe = 1'b0;
  endtask

  task automatic ram_txn(input logic [23:0] addr, input logic [1:0] siz, input logic rw,
                         input logic ds, input logic cbreq);
    bit hit, burst;
    int period, beat, n_beats, exp_rama;
    hit    = cfg_model && ((int'(addr) >> SIZE_LOG2) == (base_model >> (SIZE_LOG2 - 16)));
    burst  = BURST && hit && rw && !cbreq;
    period = WS + 1;
    n_beats = !hit ? 0 : (burst ? 4 : 1);
    @(negedge CLKCPU);
    drive_addr(addr);
    SIZ = siz; RW20 = rw; DS20 = ds; CBREQ = cbreq; AS20 = 1'b0;
    #1;
    chk("intcycle", INTCYCLE, !hit);
    chk("ramcs", RAMCS, hit ? lane_cs(int'(addr[1:0]), siz) : 4'hF);
    chk("ramoe", RAMOE, !(hit && rw));
    chk("ramwe", RAMWE, !(hit && !rw && !ds));
    chk("sterm_start", STERM, 1);
    chk("ciin", CIIN, 1);
    beat = 0;
    for (int k = 1; k <= 4 * period + 2; k++) begin
      @(negedge CLKCPU);
      if (STERM == 1'b0) begin
        beat++;
        exp_rama = (int'(addr[3:2]) + beat - 1) % 4;
        chk("beat_time", k, beat * period);
        chk("rama", RAMA, exp_rama);
        chk("cback", CBACK, !(burst && beat < 4));
        if (beat > 1) chk("burst_cs", RAMCS, 4'h0);
      end
    end
    chk("beats", beat, n_beats);
    AS20 = 1'b1; DS20 = 1'b1;
  endtask

  initial begin
    int zl[10] = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 19};
    logic [23:0] a;
    logic [1:0]  s;
    logic        rw, ds, cb;

    RESET = 1'b0; A = '0; A0 = 1'b0; SIZ = 2'b00;
    AS20 = 1'b1; DS20 = 1'b1; RW20 = 1'b1; CBREQ = 1'b1;
    tb_d_oe = 1'b0; tb_d_val = 8'h00;
    do_reset();

    foreach (zl[i]) z2_read(zl[i], z2_expect(zl[i]), 1'b1);

    // shutup hides the board until the next reset
    z2_write(7'h26, 4'h0);
    z2_read(0, 4'hE, 1'b0);
    chk("cfg_after_shutup", CONFIGURED, 0);
    do_reset();
    z2_read(0, 4'hE, 1'b1);

    z2_write(7'h25, 4'h2);
    chk("cfg_after_low_nibble", CONFIGURED, 0);
    z2_write(7'h24, 4'h4);
    chk("cfg_after_high_nibble", CONFIGURED, 1);
    cfg_model  = 1'b1;
    base_model = 8'h42;
    z2_read(0, 4'hE, 1'b0);

    ram_txn(24'h400000, 2'b00, 1'b1, 1'b0, 1'b1);
    ram_txn(24'h400001, 2'b01, 1'b0, 1'b0, 1'b1);
    ram_txn(24'h400001, 2'b01, 1'b0, 1'b1, 1'b1);
    ram_txn(24'h400008, 2'b00, 1'b1, 1'b0, 1'b0);
    ram_txn(24'h7FFFFC, 2'b00, 1'b0, 1'b0, 1'b0);
    ram_txn(24'h800000, 2'b00, 1'b1, 1'b0, 1'b1);
    ram_txn(24'h3FFFFC, 2'b10, 1'b0, 1'b0, 1'b1);

    // abort: strobe negated one edge into the wait; the next cycle must start from idle
    @(negedge CLKCPU);
    drive_addr(24'h400010);
    SIZ = 2'b00; RW20 = 1'b1; DS20 = 1'b0; CBREQ = 1'b1; AS20 = 1'b0;
    @(negedge CLKCPU);
    chk("abort_pre_sterm", STERM, 1);
    AS20 = 1'b1; DS20 = 1'b1;
    #1;
    chk("abort_sterm", STERM, 1);
    ram_txn(24'h400020, 2'b00, 1'b1, 1'b0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) != 0) a = 24'h400000 | 24'($urandom & 32'h3FFFFF);
      else a = 24'($urandom);
      s  = 2'($urandom);
      rw = 1'($urandom);
      cb = 1'($urandom);
      ds = rw ? 1'b0 : 1'($urandom);
      if (rw && !cb) begin
        s = 2'b00;
        a[1:0] = 2'b00;
      end
      ram_txn(a, s, rw, ds, cb);
    end

    // synchronous reset in the middle of a cycle (second burst beat when bursts are built)
    @(negedge CLKCPU);
    drive_addr(24'h400008);
    SIZ = 2'b00; RW20 = 1'b1; DS20 = 1'b0; CBREQ = 1'b0; AS20 = 1'b0;
    repeat (2 * (WS + 1)) @(negedge CLKCPU);
    chk("pre_reset_sterm", STERM, !BURST);
    chk("pre_reset_cback", CBACK, !BURST);
    RESET = 1'b0;
    @(negedge CLKCPU);
    check_reset_outputs("midcycle_reset");
    RESET = 1'b1; AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
